// File: rtl/edge_frame_packer.sv
// Buffers packed edge bytes in a small FIFO and frames each image as sync word, frame id, payload
// and optional checksum (enabled by EDGE_FRAME_CHECKSUM_EN) onto a uart_tx-style byte interface.
module edge_frame_packer #(
    parameter int          IMAGE_WIDTH  = 320,
    parameter int          IMAGE_HEIGHT = 240,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] frame_id
);

    localparam int          PAYLOAD_BYTES = IMAGE_WIDTH * IMAGE_HEIGHT / 8;
    localparam int          PTR_W         = $clog2(FIFO_DEPTH);
    localparam logic [15:0] PAY_LAST      = 16'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_ID,
        S_PAY,
`ifdef EDGE_FRAME_CHECKSUM_EN
        S_TRL,
`endif
        S_END
    } state_t;

    state_t           state_reg, state_next;
    logic             issued_reg;
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic [15:0]      pay_cnt_reg;
    logic [7:0]       frame_id_reg;
    logic             overflow_reg;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
`ifdef EDGE_FRAME_CHECKSUM_EN
    logic [7:0]       checksum_reg;
`endif

    logic fifo_empty, fifo_full, push, pop, sending, can_issue, done;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign busy     = (state_reg != S_IDLE);
    assign in_ready = busy && !fifo_full;
    assign push     = in_valid && in_ready;
    assign overflow = overflow_reg;
    assign frame_id = frame_id_reg;

    // A byte stays offered from the moment it is issued until the UART reports busy.
    assign sending   = busy && (state_reg != S_END);
    assign can_issue = !tx_busy && ((state_reg != S_PAY) || !fifo_empty);
    assign tx_start  = sending && (issued_reg || can_issue);
    assign done      = sending && issued_reg && tx_busy;
    assign pop       = done && (state_reg == S_PAY);

    always_comb begin
        state_next = state_reg;
        tx_byte    = 8'h00;
        case (state_reg)
            S_IDLE: if (frame_start) state_next = S_HDR0;
            S_HDR0: begin
                tx_byte = SYNC_WORD[15:8];
                if (done) state_next = S_HDR1;
            end
            S_HDR1: begin
                tx_byte = SYNC_WORD[7:0];
                if (done) state_next = S_ID;
            end
            S_ID: begin
                tx_byte = frame_id_reg;
                if (done) state_next = S_PAY;
            end
            S_PAY: begin
                tx_byte = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
                if (done && (pay_cnt_reg == PAY_LAST)) begin
`ifdef EDGE_FRAME_CHECKSUM_EN
                    state_next = S_TRL;
`else
                    state_next = S_END;
`endif
                end
            end
`ifdef EDGE_FRAME_CHECKSUM_EN
            S_TRL: begin
                tx_byte = checksum_reg;
                if (done) state_next = S_END;
            end
`endif
            S_END:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            issued_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pay_cnt_reg  <= 16'd0;
            frame_id_reg <= 8'd0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (done)
                issued_reg <= 1'b0;
            else if (tx_start)
                issued_reg <= 1'b1;
            if (in_valid && !in_ready)
                overflow_reg <= 1'b1;
            // END flushes any surplus payload and rearms for the next frame.
            if (state_reg == S_END) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                pay_cnt_reg  <= 16'd0;
                frame_id_reg <= frame_id_reg + 8'd1;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                    pay_cnt_reg <= pay_cnt_reg + 16'd1;
                end
            end
        end
    end

`ifdef EDGE_FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            checksum_reg <= 8'd0;
        else if (state_reg == S_END)
            checksum_reg <= 8'd0;
        else if (done && ((state_reg == S_ID) || (state_reg == S_PAY)))
            checksum_reg <= checksum_reg + tx_byte;
    end
`endif

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= in_byte;
    end

endmodule

// File: tb/tb_edge_frame_packer.sv
// Scoreboard bench for edge_frame_packer: two instances (small image, and depth-2 FIFO for
// back-pressure), each driven by a 10-cycle behavioural UART and checked byte by byte.
`timescale 1ns/1ps
module tb_edge_frame_packer;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Main instance: 8x2 image, 2 payload bytes
    logic       frame_start, in_valid, in_ready, tx_busy, tx_start, busy, overflow;
    logic [7:0] in_byte, tx_byte, frame_id;
    // Back-pressure instance: 8x8 image, 8 payload bytes, FIFO depth 2
    logic       b_frame_start, b_in_valid, b_in_ready, b_tx_busy, b_tx_start, b_busy, b_overflow;
    logic [7:0] b_in_byte, b_tx_byte, b_frame_id;

    edge_frame_packer #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .FIFO_DEPTH(16), .SYNC_WORD(16'hA55A)) dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_byte(tx_byte), .busy(busy), .overflow(overflow), .frame_id(frame_id));

    edge_frame_packer #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .FIFO_DEPTH(2), .SYNC_WORD(16'hA55A)) dut_bp (
        .clk(clk), .resetn(resetn), .frame_start(b_frame_start), .in_valid(b_in_valid),
        .in_byte(b_in_byte), .in_ready(b_in_ready), .tx_busy(b_tx_busy), .tx_start(b_tx_start),
        .tx_byte(b_tx_byte), .busy(b_busy), .overflow(b_overflow), .frame_id(b_frame_id));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] b_exp_q[$];
    logic [7:0] model_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural UART: accepts a byte when idle, then busy for 10 cycles.
    int u_cnt, bu_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_busy <= 1'b0; u_cnt <= 0;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) tx_busy <= 1'b0;
        end else if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1; u_cnt <= 10;
        end
    end
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_tx_busy <= 1'b0; bu_cnt <= 0;
        end else if (bu_cnt != 0) begin
            bu_cnt <= bu_cnt - 1;
            if (bu_cnt == 1) b_tx_busy <= 1'b0;
        end else if (b_tx_start && !b_tx_busy) begin
            b_tx_busy <= 1'b1; bu_cnt <= 10;
        end
    end

    // Monitors: a byte goes on the line whenever the UART is about to accept one.
    always @(negedge clk) begin
        if (resetn && tx_start && !tx_busy) begin
            if (exp_q.size() == 0) begin
                chk("line_unexpected", {24'd0, tx_byte}, 32'h100);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("line byte %02h expected %02h", tx_byte, e);
                chk("line_byte", {24'd0, tx_byte}, {24'd0, e});
            end
        end
    end
    always @(negedge clk) begin
        if (resetn && b_tx_start && !b_tx_busy) begin
            if (b_exp_q.size() == 0) begin
                chk("bp_line_unexpected", {24'd0, b_tx_byte}, 32'h100);
            end else begin
                logic [7:0] e;
                e = b_exp_q.pop_front();
                $display("bp line byte %02h expected %02h", b_tx_byte, e);
                chk("bp_line_byte", {24'd0, b_tx_byte}, {24'd0, e});
            end
        end
    end

    // Reference frame: header, id, payload, then the mod-256 sum of id and payload.
    task automatic expect_frame(input logic [7:0] id, input logic [7:0] p0, input logic [7:0] p1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(id);
        exp_q.push_back(p0);    exp_q.push_back(p1);
`ifdef EDGE_FRAME_CHECKSUM_EN
        exp_q.push_back(8'((int'(id) + int'(p0) + int'(p1)) % 256));
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk); frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
    endtask

    task automatic push_main(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        while (!in_ready && n < 3000) begin @(negedge clk); n++; end
        if (!in_ready) chk("push_ready", {31'd0, in_ready}, 32'd1);
        else begin
            in_valid = 1'b1; in_byte = b;
            @(posedge clk); #1; in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        chk("frame_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input bit dup_start);
        expect_frame(model_id, p0, p1);
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        if (!tx_busy) chk("tx_start_after_start", {31'd0, tx_start}, 32'd1);
        push_main(p0);
        if (dup_start) pulse_start();
        push_main(p1);
        wait_idle();
        model_id = model_id + 8'd1;
        chk("frame_id", {24'd0, frame_id}, {24'd0, model_id});
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_data [8];
        int n;
        resetn = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        b_frame_start = 1'b0; b_in_valid = 1'b0; b_in_byte = 8'h00;
        model_id = 8'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_id", {24'd0, frame_id}, 32'd0);

        // Basic frame: A5 5A 00 81 FF (80)
        run_frame(8'h81, 8'hFF, 1'b0);

        // Overflow while idle; the dropped byte must not reach the next frame
        @(negedge clk); in_valid = 1'b1; in_byte = 8'h3C;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        run_frame(8'($urandom), 8'($urandom), 1'b0);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Random frames, some with a stray frame_start mid-frame
        repeat (4) run_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Run to id FF, then the zero-payload checksum case and the wrapped id
        while (model_id != 8'hFF) run_frame(8'($urandom), 8'($urandom), 1'b0);
        run_frame(8'h00, 8'h00, 1'b0);
        chk("frame_id_wrap", {24'd0, frame_id}, 32'd0);
        run_frame(8'($urandom), 8'($urandom), 1'b0);

        // Back-pressure: depth-2 FIFO fills while the header is still on the line
        for (int i = 0; i < 8; i++) bp_data[i] = 8'($urandom);
        b_exp_q.push_back(8'hA5); b_exp_q.push_back(8'h5A); b_exp_q.push_back(8'h00);
        begin
            int sum = 0;
            for (int i = 0; i < 8; i++) begin b_exp_q.push_back(bp_data[i]); sum += bp_data[i]; end
`ifdef EDGE_FRAME_CHECKSUM_EN
            b_exp_q.push_back(8'(sum % 256));
`endif
        end
        @(negedge clk); b_frame_start = 1'b1;
        @(posedge clk); #1; b_frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!b_in_ready && n < 3000) begin @(negedge clk); n++; end
            if (!b_in_ready) chk("bp_push_ready", {31'd0, b_in_ready}, 32'd1);
            b_in_valid = 1'b1; b_in_byte = bp_data[i];
            @(posedge clk); #1; b_in_valid = 1'b0;
            if (i == 1) chk("bp_in_ready_full", {31'd0, b_in_ready}, 32'd0);
        end
        n = 0;
        while (b_busy && n < 3000) begin @(negedge clk); n++; end
        chk("bp_frame_end", {31'd0, b_busy}, 32'd0);
        chk("bp_overflow", {31'd0, b_overflow}, 32'd0);
        chk("bp_frame_id", {24'd0, b_frame_id}, 32'd1);
        chk("bp_queue_drained", b_exp_q.size(), 32'd0);

        // Reset during PAY
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(model_id);
        exp_q.push_back(8'h5E);
        pulse_start();
        push_main(8'h5E);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        chk("pay_reached", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b0; #1;
        chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_frame_id", {24'd0, frame_id}, 32'd0);
        exp_q.delete();
        model_id = 8'd0;
        @(negedge clk); resetn = 1'b1;
        run_frame(8'($urandom), 8'($urandom), 1'b0);

        repeat (20) @(negedge clk);
        chk("final_queue", exp_q.size() + b_exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
